// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_if
// Description : SRAM-like bus between the core (master) and the memory
//               responder (slave). Carries the instruction read port and the
//               data read/write port.
//               inst_sram_en     core -> mem  instruction read request
//               inst_sram_addr   core -> mem  instruction byte address
//               inst_sram_rdata  mem -> core  instruction read data
//               data_sram_en     core -> mem  data access request
//               data_sram_wen    core -> mem  byte write enables (lane i = bits 8i+7:8i)
//               data_sram_addr   core -> mem  data byte address
//               data_sram_wdata  core -> mem  data write data
//               data_sram_rdata  mem -> core  data read data
// Revision    : 1.0  initial release
// ============================================================================
interface sram_responder_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Memory-side responder for the core's instruction and data
//               SRAM-like ports. One shared word array serves both ports
//               (read-first on collisions). Reads return after READ_LATENCY
//               cycles through a fully pipelined per-port read pipeline.
//               Optional MMIO window on the data port (cycle counter at
//               offset 0x000, LED register at offset 0x004), compiled in when
//               the macro SRAM_RESPONDER_MMIO_EN is defined.
// Ports       : clk    - clock, all state updates on the rising edge
//               reset  - synchronous active-high reset
//               sram   - sram_responder_if.slave (inst + data SRAM ports)
//               led    - LED register output (0 when MMIO is not compiled in)
// Parameters  : ADDR_WIDTH   - word index bits (depth 2^ADDR_WIDTH words)
//               READ_LATENCY - read latency in cycles, 1..3
//               MMIO_BASE    - 4 KB aligned MMIO window base (data port)
// Revision    : 1.0  initial release
// ============================================================================
module sram_responder #(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] MMIO_BASE    = 32'hBFAF_F000
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_responder_if.slave        sram,
    output logic [15:0]            led
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------------
    // Shared word array (no reset: contents survive reset)
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [c_DEPTH];

    logic [ADDR_WIDTH-1:0] w_inst_idx;
    logic [ADDR_WIDTH-1:0] w_data_idx;
    logic                  w_data_wr;      // data port write request
    logic                  w_arr_we;       // write that actually targets the array
    logic [31:0]           w_data_rd_word; // word the data port would capture

    assign w_inst_idx = sram.inst_sram_addr[ADDR_WIDTH+1:2];
    assign w_data_idx = sram.data_sram_addr[ADDR_WIDTH+1:2];
    assign w_data_wr  = sram.data_sram_en && (sram.data_sram_wen != 4'b0000);

    // Byte offset bits and aliased upper bits are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{sram.inst_sram_addr, sram.data_sram_addr};

    // Array reads in the pipelines below sample r_mem before this update
    // lands, which gives read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (!reset && w_arr_we) begin
            for (int i = 0; i < 4; i++) begin
                if (sram.data_sram_wen[i]) begin
                    r_mem[w_data_idx][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef SRAM_RESPONDER_MMIO_EN
    // ------------------------------------------------------------------------
    // MMIO window: cycle counter and LED register
    // ------------------------------------------------------------------------
    logic        w_mmio_hit;
    logic        w_cnt_sel;
    logic        w_led_sel;
    logic [31:0] r_cnt_q;
    logic [31:0] w_cnt_d;
    logic [15:0] r_led_q;
    logic [15:0] w_led_d;
    logic [31:0] w_mmio_rdata;

    assign w_mmio_hit = (sram.data_sram_addr[31:12] == MMIO_BASE[31:12]);
    assign w_cnt_sel  = w_mmio_hit && (sram.data_sram_addr[11:2] == 10'd0);
    assign w_led_sel  = w_mmio_hit && (sram.data_sram_addr[11:2] == 10'd1);

    always_comb begin
        // A counter write replaces the increment for that cycle.
        w_cnt_d = r_cnt_q + 32'd1;
        if (w_data_wr && w_cnt_sel) begin
            w_cnt_d = r_cnt_q;
            for (int i = 0; i < 4; i++) begin
                if (sram.data_sram_wen[i]) begin
                    w_cnt_d[8*i +: 8] = sram.data_sram_wdata[8*i +: 8];
                end
            end
        end

        // Only the low two byte lanes exist in the LED register.
        w_led_d = r_led_q;
        if (w_data_wr && w_led_sel) begin
            for (int i = 0; i < 2; i++) begin
                if (sram.data_sram_wen[i]) begin
                    w_led_d[8*i +: 8] = sram.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_mmio_rdata = 32'd0;
        if (w_cnt_sel) begin
            w_mmio_rdata = r_cnt_q;
        end else if (w_led_sel) begin
            w_mmio_rdata = {16'd0, r_led_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= 32'd0;
            r_led_q <= 16'd0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_led_q <= w_led_d;
        end
    end

    assign w_arr_we       = w_data_wr && !w_mmio_hit;
    assign w_data_rd_word = w_mmio_hit ? w_mmio_rdata : r_mem[w_data_idx];
    assign led            = r_led_q;
`else
    assign w_arr_we       = w_data_wr;
    assign w_data_rd_word = r_mem[w_data_idx];
    assign led            = 16'd0;
`endif

    // ------------------------------------------------------------------------
    // Read pipelines: stage 0 captures on en and holds otherwise; later
    // stages shift every cycle. rdata is the last stage.
    // ------------------------------------------------------------------------
    logic [31:0] r_inst_pipe_q [READ_LATENCY];
    logic [31:0] w_inst_pipe_d [READ_LATENCY];
    logic [31:0] r_data_pipe_q [READ_LATENCY];
    logic [31:0] w_data_pipe_d [READ_LATENCY];

    always_comb begin
        w_inst_pipe_d[0] = sram.inst_sram_en ? r_mem[w_inst_idx] : r_inst_pipe_q[0];
        w_data_pipe_d[0] = sram.data_sram_en ? w_data_rd_word    : r_data_pipe_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_inst_pipe_d[i] = r_inst_pipe_q[i-1];
            w_data_pipe_d[i] = r_data_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_inst_pipe_q[i] <= 32'd0;
                r_data_pipe_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_inst_pipe_q[i] <= w_inst_pipe_d[i];
                r_data_pipe_q[i] <= w_data_pipe_d[i];
            end
        end
    end

    assign sram.inst_sram_rdata = r_inst_pipe_q[READ_LATENCY-1];
    assign sram.data_sram_rdata = r_data_pipe_q[READ_LATENCY-1];

endmodule
`default_nettype wire
